// File: rtl/periph_gpio_intc_if.sv
// Split read/write register-bus bundle (Wishbone FASM style) for periph_gpio_intc.
// The master drives strobes/address/data; the slave returns read data and acks.
interface periph_gpio_intc_if #(
  parameter int ADDR_BITS = 4
);
  logic                 WB_RD_STB_I;
  logic [ADDR_BITS-1:0] WB_RD_ADR_I;
  logic [31:0]          WB_RD_DAT_O;
  logic                 WB_RD_ACK_O;

  logic                 WB_WR_STB_I;
  logic                 WB_WR_WE_I;
  logic [3:0]           WB_WR_SEL_I;
  logic [ADDR_BITS-1:0] WB_WR_ADR_I;
  logic [31:0]          WB_WR_DAT_I;
  logic                 WB_WR_ACK_O;

  modport master (
    output WB_RD_STB_I, WB_RD_ADR_I,
    input  WB_RD_DAT_O, WB_RD_ACK_O,
    output WB_WR_STB_I, WB_WR_WE_I, WB_WR_SEL_I, WB_WR_ADR_I, WB_WR_DAT_I,
    input  WB_WR_ACK_O
  );

  modport slave (
    input  WB_RD_STB_I, WB_RD_ADR_I,
    output WB_RD_DAT_O, WB_RD_ACK_O,
    input  WB_WR_STB_I, WB_WR_WE_I, WB_WR_SEL_I, WB_WR_ADR_I, WB_WR_DAT_I,
    output WB_WR_ACK_O
  );
endinterface

// File: rtl/periph_gpio_intc.sv
// GPIO port plus external-interrupt controller (enable, edge/level mode, W1C pending).
// Optional per-source input debounce is built when PERIPH_INTX_DEBOUNCE_EN is defined.
module periph_gpio_intc #(
  parameter int NUM_GPIOS    = 32,
  parameter int NUM_INTX     = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int ADDR_BITS    = 4,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  periph_gpio_intc_if.slave    bus,
  input  logic [NUM_INTX-1:0]  INTx,
  input  logic [NUM_GPIOS-1:0] gpio_in,
  output logic [NUM_GPIOS-1:0] gpio_out,
  output logic                 int_gen
);

  localparam logic [ADDR_BITS-1:0] A_GPIO_OUT = ADDR_BITS'(0);
  localparam logic [ADDR_BITS-1:0] A_GPIO_IN  = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] A_INT_EN   = ADDR_BITS'(2);
  localparam logic [ADDR_BITS-1:0] A_INT_MODE = ADDR_BITS'(3);
  localparam logic [ADDR_BITS-1:0] A_INT_PEND = ADDR_BITS'(4);
  localparam logic [ADDR_BITS-1:0] A_INT_RAW  = ADDR_BITS'(5);

  logic [NUM_INTX-1:0]  intx_sync [SYNC_STAGES];
  logic [NUM_GPIOS-1:0] gpio_sync [SYNC_STAGES];
  logic [NUM_INTX-1:0]  intx_stable;
  logic [NUM_GPIOS-1:0] gpio_stable;
  logic [NUM_INTX-1:0]  intx_prev;

  logic [NUM_INTX-1:0]  int_en;
  logic [NUM_INTX-1:0]  int_mode;
  logic [NUM_INTX-1:0]  int_pend;
  logic [NUM_INTX-1:0]  pend_nxt;
  logic [NUM_INTX-1:0]  rise;
  logic [NUM_INTX-1:0]  w1c_mask;
  logic [NUM_INTX-1:0]  rearm_mask;
  logic [NUM_INTX-1:0]  wr_low;

  logic        wr_fire;
  logic        wr_gpio_out;
  logic        wr_int_en;
  logic        wr_int_mode;
  logic        wr_int_pend;
  logic        wr_ack;
  logic        rd_ack;
  logic [31:0] rd_dat;
  logic [31:0] rd_mux;

  // Both asynchronous input groups cross into the clock domain here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        intx_sync[i] <= '0;
        gpio_sync[i] <= '0;
      end
    end else begin
      intx_sync[0] <= INTx;
      gpio_sync[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        intx_sync[i] <= intx_sync[i-1];
        gpio_sync[i] <= gpio_sync[i-1];
      end
    end
  end

  assign gpio_stable = gpio_sync[SYNC_STAGES-1];

`ifdef PERIPH_INTX_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYC);

  logic [CNT_W-1:0]    deb_cnt [NUM_INTX];
  logic [NUM_INTX-1:0] intx_deb;
  logic [NUM_INTX-1:0] intx_raw_s;

  assign intx_raw_s = intx_sync[SYNC_STAGES-1];

  // A source only flips once DEBOUNCE_CYC back-to-back samples disagree with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      intx_deb <= '0;
      for (int k = 0; k < NUM_INTX; k++) deb_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_INTX; k++) begin
        if (intx_raw_s[k] == intx_deb[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == CNT_W'(DEBOUNCE_CYC - 1)) begin
          intx_deb[k] <= intx_raw_s[k];
          deb_cnt[k]  <= '0;
        end else begin
          deb_cnt[k] <= deb_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign intx_stable = intx_deb;
`else
  assign intx_stable = intx_sync[SYNC_STAGES-1];
`endif

  assign wr_fire     = bus.WB_WR_STB_I & bus.WB_WR_WE_I;
  assign wr_gpio_out = wr_fire && (bus.WB_WR_ADR_I == A_GPIO_OUT);
  assign wr_int_en   = wr_fire && (bus.WB_WR_ADR_I == A_INT_EN);
  assign wr_int_mode = wr_fire && (bus.WB_WR_ADR_I == A_INT_MODE);
  assign wr_int_pend = wr_fire && (bus.WB_WR_ADR_I == A_INT_PEND);
  assign wr_low      = bus.WB_WR_DAT_I[NUM_INTX-1:0];

  // Only GPIO_OUT is byte-laned; the interrupt registers take the full word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_out <= '0;
      int_en   <= '0;
      int_mode <= '0;
      wr_ack   <= 1'b0;
    end else begin
      wr_ack <= wr_fire;
      if (wr_gpio_out) begin
        for (int b = 0; b < NUM_GPIOS / 8; b++) begin
          if (bus.WB_WR_SEL_I[b]) gpio_out[b*8 +: 8] <= bus.WB_WR_DAT_I[b*8 +: 8];
        end
      end
      if (wr_int_en)   int_en   <= wr_low;
      if (wr_int_mode) int_mode <= wr_low;
    end
  end

  // A new rise beats a same-cycle W1C; a level->edge switch drops the bit until the next rise.
  assign rise       = intx_stable & ~intx_prev;
  assign w1c_mask   = wr_int_pend ? wr_low : '0;
  assign rearm_mask = wr_int_mode ? (wr_low & ~int_mode) : '0;

  always_comb begin
    pend_nxt = '0;
    pend_nxt = ~rearm_mask &
               ((int_mode & ((int_pend & ~w1c_mask) | rise)) |
                (~int_mode & intx_stable));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      intx_prev <= '0;
      int_pend  <= '0;
      int_gen   <= 1'b0;
    end else begin
      intx_prev <= intx_stable;
      int_pend  <= pend_nxt;
      int_gen   <= |(int_pend & int_en);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.WB_RD_ADR_I)
      A_GPIO_OUT: rd_mux = 32'(gpio_out);
      A_GPIO_IN:  rd_mux = 32'(gpio_stable);
      A_INT_EN:   rd_mux = 32'(int_en);
      A_INT_MODE: rd_mux = 32'(int_mode);
      A_INT_PEND: rd_mux = 32'(int_pend);
      A_INT_RAW:  rd_mux = 32'(intx_stable);
      default:    rd_mux = '0;
    endcase
  end

  // Read data is captured from pre-write register state, so a colliding write is not visible yet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_dat <= '0;
      rd_ack <= 1'b0;
    end else begin
      rd_ack <= bus.WB_RD_STB_I;
      if (bus.WB_RD_STB_I) rd_dat <= rd_mux;
    end
  end

  assign bus.WB_RD_DAT_O = rd_dat;
  assign bus.WB_RD_ACK_O = rd_ack;
  assign bus.WB_WR_ACK_O = wr_ack;

endmodule

// File: tb/tb_periph_gpio_intc.sv
// Self-checking bench for periph_gpio_intc: register vector table, interrupt corner sequences
// and a randomized run against an event-based reference model.
module tb_periph_gpio_intc;

  localparam int NG  = 32;
  localparam int NI  = 8;
  localparam int SS  = 2;
  localparam int AB  = 4;
  localparam int DEB = 16;
`ifdef PERIPH_INTX_DEBOUNCE_EN
  localparam int LAT = SS + 2 + DEB;
  localparam int WIN = DEB;
  localparam int DLY = SS;
`else
  localparam int LAT = SS + 2;
  localparam int WIN = 1;
  localparam int DLY = SS - 1;
`endif
  localparam int NR  = 200;

  logic          clk;
  logic          reset;
  logic [NI-1:0] intx;
  logic [NG-1:0] gpio_in;
  logic [NG-1:0] gpio_out;
  logic          int_gen;

  int n_cmp  = 0;
  int n_fail = 0;

  periph_gpio_intc_if #(.ADDR_BITS(AB)) bus ();

  periph_gpio_intc #(
    .NUM_GPIOS(NG), .NUM_INTX(NI), .SYNC_STAGES(SS), .ADDR_BITS(AB), .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .INTx(intx),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .int_gen(int_gen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[11];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus.WB_WR_STB_I = 1'b1;
    bus.WB_WR_WE_I  = 1'b1;
    bus.WB_WR_ADR_I = adr;
    bus.WB_WR_DAT_I = dat;
    bus.WB_WR_SEL_I = sel;
    tick(1);
    bus.WB_WR_STB_I = 1'b0;
    bus.WB_WR_WE_I  = 1'b0;
    check_output("wr_ack", {31'b0, bus.WB_WR_ACK_O}, 32'd1);
  endtask

  task automatic bus_read(input logic [3:0] adr, output logic [31:0] dat);
    bus.WB_RD_STB_I = 1'b1;
    bus.WB_RD_ADR_I = adr;
    tick(1);
    bus.WB_RD_STB_I = 1'b0;
    check_output("rd_ack", {31'b0, bus.WB_RD_ACK_O}, 32'd1);
    dat = bus.WB_RD_DAT_O;
  endtask

  task automatic read_check(input string name, input logic [3:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(adr, d);
    check_output(name, d, exp);
  endtask

  // Reference: filtered input history, rise/clear event times, pending derived from their order.
  task automatic random_round(input logic [7:0] mode_r, input logic [7:0] en_r);
    logic [NI-1:0] raw [NR+1];
    logic [NI-1:0] f   [NR+1];
    logic [NI-1:0] p   [NR+1];
    int            last_det [NI];
    int            last_clr [NI];
    logic [NI-1:0] w1c, s1, s2;
    logic          do_rd, all_eq, exp_g;
    int            idx;

    intx = '0;
    apply_stimulus(4'd3, {24'h0, mode_r}, 4'h0);
    apply_stimulus(4'd2, {24'h0, en_r}, 4'h0);
    tick(WIN + SS + 6);
    apply_stimulus(4'd4, 32'h0000_00FF, 4'h0);
    tick(3);

    raw[0] = '0;
    f[0]   = '0;
    p[0]   = '0;
    for (int k = 0; k < NI; k++) begin
      last_det[k] = -1;
      last_clr[k] = -1;
    end

    for (int t = 1; t <= NR; t++) begin
      raw[t] = raw[t-1];
      if ($urandom_range(WIN + 2) == 0) raw[t] = raw[t] ^ NI'($urandom);
      intx = raw[t];
      w1c  = ($urandom_range(5) == 0) ? NI'($urandom) : '0;
      if (w1c != '0) begin
        bus.WB_WR_STB_I = 1'b1;
        bus.WB_WR_WE_I  = 1'b1;
        bus.WB_WR_ADR_I = 4'd4;
        bus.WB_WR_SEL_I = 4'($urandom);
        bus.WB_WR_DAT_I = {24'($urandom), w1c};
      end
      do_rd = ($urandom_range(2) == 0);
      bus.WB_RD_STB_I = do_rd;
      bus.WB_RD_ADR_I = 4'd4;
      tick(1);
      bus.WB_WR_STB_I = 1'b0;
      bus.WB_WR_WE_I  = 1'b0;
      bus.WB_RD_STB_I = 1'b0;

      for (int k = 0; k < NI; k++) begin
        all_eq = 1'b1;
        for (int j = 0; j < WIN; j++) begin
          idx = t - j;
          if (((idx >= 0) ? raw[idx][k] : 1'b0) != raw[t][k]) all_eq = 1'b0;
        end
        f[t][k] = all_eq ? raw[t][k] : f[t-1][k];
      end
      idx = t - 1 - DLY;
      s1  = (idx >= 0) ? f[idx] : '0;
      idx = t - 2 - DLY;
      s2  = (idx >= 0) ? f[idx] : '0;
      for (int k = 0; k < NI; k++) begin
        if (s1[k] && !s2[k]) last_det[k] = t;
        if (w1c[k]) last_clr[k] = t;
        p[t][k] = mode_r[k] ? (last_det[k] >= 0 && last_det[k] >= last_clr[k]) : s1[k];
      end

      exp_g = |(p[t-1] & en_r);
      check_output("rand_int_gen", {31'b0, int_gen}, {31'b0, exp_g});
      if (do_rd) begin
        check_output("rand_rd_ack", {31'b0, bus.WB_RD_ACK_O}, 32'd1);
        check_output("rand_pend_rd", bus.WB_RD_DAT_O, 32'(p[t-1]));
      end
    end
    intx = '0;
    tick(WIN + SS + 6);
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first;

    vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[1]  = '{4'd0,  32'h1234_5678, 4'h8, 32'h12FF_FFFF, 32'h12FF_FFFF};
    vecs[2]  = '{4'd0,  32'h0000_0000, 4'h6, 32'h1200_00FF, 32'h1200_00FF};
    vecs[3]  = '{4'd2,  32'hFFFF_FF5A, 4'h0, 32'h0000_005A, 32'h1200_00FF};
    vecs[4]  = '{4'd3,  32'h0000_00C3, 4'h1, 32'h0000_00C3, 32'h1200_00FF};
    vecs[5]  = '{4'd1,  32'hFFFF_FFFF, 4'hF, 32'hCAFE_F00D, 32'h1200_00FF};
    vecs[6]  = '{4'd6,  32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 32'h1200_00FF};
    vecs[7]  = '{4'd5,  32'h0000_00FF, 4'hF, 32'h0000_0000, 32'h1200_00FF};
    vecs[8]  = '{4'd3,  32'h0000_0000, 4'hF, 32'h0000_0000, 32'h1200_00FF};
    vecs[9]  = '{4'd2,  32'h0000_0000, 4'h0, 32'h0000_0000, 32'h1200_00FF};
    vecs[10] = '{4'd15, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 32'h1200_00FF};

    reset           = 1'b1;
    intx            = '0;
    gpio_in         = 32'hCAFE_F00D;
    bus.WB_RD_STB_I = 1'b0;
    bus.WB_RD_ADR_I = '0;
    bus.WB_WR_STB_I = 1'b0;
    bus.WB_WR_WE_I  = 1'b0;
    bus.WB_WR_SEL_I = '0;
    bus.WB_WR_ADR_I = '0;
    bus.WB_WR_DAT_I = '0;
    tick(3);
    check_output("rst_gpio_out", gpio_out, 32'h0);
    check_output("rst_int_gen", {31'b0, int_gen}, 32'h0);
    check_output("rst_wr_ack", {31'b0, bus.WB_WR_ACK_O}, 32'h0);
    check_output("rst_rd_ack", {31'b0, bus.WB_RD_ACK_O}, 32'h0);
    check_output("rst_rd_dat", bus.WB_RD_DAT_O, 32'h0);
    reset = 1'b0;
    tick(2);

    $display("[TB] reset asserted in the middle of a GPIO_OUT write");
    bus.WB_WR_STB_I = 1'b1;
    bus.WB_WR_WE_I  = 1'b1;
    bus.WB_WR_ADR_I = 4'd0;
    bus.WB_WR_DAT_I = 32'hA5A5_A5A5;
    bus.WB_WR_SEL_I = 4'hF;
    bus.WB_RD_STB_I = 1'b1;
    bus.WB_RD_ADR_I = 4'd0;
    tick(1);
    check_output("t1_gpio_before_rst", gpio_out, 32'hA5A5_A5A5);
    check_output("t1_ack_before_rst", {31'b0, bus.WB_WR_ACK_O}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_output("t1_gpio_out", gpio_out, 32'h0);
    check_output("t1_int_gen", {31'b0, int_gen}, 32'h0);
    check_output("t1_wr_ack", {31'b0, bus.WB_WR_ACK_O}, 32'h0);
    check_output("t1_rd_ack", {31'b0, bus.WB_RD_ACK_O}, 32'h0);
    bus.WB_WR_STB_I = 1'b0;
    bus.WB_WR_WE_I  = 1'b0;
    bus.WB_RD_STB_I = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
    read_check("t1_read_after_rst", 4'd0, 32'h0);

    $display("[TB] byte-select write of GPIO_OUT");
    apply_stimulus(4'd0, 32'h1122_3344, 4'b0101);
    check_output("t2_gpio_out", gpio_out, 32'h0022_0044);
    tick(1);
    check_output("t2_ack_pulse", {31'b0, bus.WB_WR_ACK_O}, 32'h0);
    read_check("t2_readback", 4'd0, 32'h0022_0044);

    $display("[TB] register vector table");
    tick(SS + 2);
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].adr, vecs[i].wdat, vecs[i].sel);
      check_output($sformatf("vec%0d_gpio_out", i), gpio_out, vecs[i].exp_out);
      read_check($sformatf("vec%0d_read", i), vecs[i].adr, vecs[i].exp_rd);
    end

    $display("[TB] edge interrupt latency and W1C");
    apply_stimulus(4'd3, 32'h1, 4'hF);
    apply_stimulus(4'd2, 32'h1, 4'hF);
    intx  = 8'h01;
    first = -1;
    for (int i = 1; i <= LAT + 30; i++) begin
      tick(1);
      if (int_gen && first < 0) first = i;
      if (i == 3 + LAT - SS - 2) intx = 8'h00;
    end
    check_output("t3_latency", 32'(first), 32'(LAT));
    read_check("t3_pend", 4'd4, 32'h1);
    apply_stimulus(4'd4, 32'h1, 4'h0);
    check_output("t3_int_gen_w1c_edge", {31'b0, int_gen}, 32'd1);
    tick(1);
    check_output("t3_int_gen_cleared", {31'b0, int_gen}, 32'd0);
    read_check("t3_pend_cleared", 4'd4, 32'h0);

    $display("[TB] level interrupt ignores W1C");
    apply_stimulus(4'd3, 32'h0, 4'hF);
    apply_stimulus(4'd2, 32'h4, 4'hF);
    intx = 8'h04;
    tick(LAT + 2);
    check_output("t4_int_gen_level", {31'b0, int_gen}, 32'd1);
    apply_stimulus(4'd4, 32'h4, 4'hF);
    tick(2);
    check_output("t4_int_gen_after_w1c", {31'b0, int_gen}, 32'd1);
    read_check("t4_pend", 4'd4, 32'h4);
    read_check("t4_raw", 4'd5, 32'h4);
    intx  = 8'h00;
    first = -1;
    for (int i = 1; i <= LAT + 10; i++) begin
      tick(1);
      if (!int_gen && first < 0) first = i;
    end
    check_output("t4_drop_latency", 32'(first), 32'(LAT));

    $display("[TB] rise coinciding with W1C");
    apply_stimulus(4'd3, 32'h2, 4'hF);
    apply_stimulus(4'd2, 32'h2, 4'hF);
    intx = 8'h02;
    tick(LAT - 2);
    apply_stimulus(4'd4, 32'h2, 4'hF);
    tick(1);
    check_output("t5_int_gen", {31'b0, int_gen}, 32'd1);
    read_check("t5_pend_kept", 4'd4, 32'h2);
    apply_stimulus(4'd2, 32'h0, 4'hF);
    tick(1);
    check_output("t5_int_gen_masked", {31'b0, int_gen}, 32'd0);
    read_check("t5_pend_masked", 4'd4, 32'h2);
    apply_stimulus(4'd4, 32'h2, 4'hF);
    read_check("t5_pend_w1c", 4'd4, 32'h0);
    intx = 8'h00;
    tick(LAT + WIN + 5);

`ifdef PERIPH_INTX_DEBOUNCE_EN
    $display("[TB] debounce glitch rejection");
    apply_stimulus(4'd3, 32'h1, 4'hF);
    apply_stimulus(4'd2, 32'h1, 4'hF);
    apply_stimulus(4'd4, 32'hFF, 4'hF);
    intx = 8'h01;
    tick(10);
    intx = 8'h00;
    tick(40);
    read_check("t6_glitch_pend", 4'd4, 32'h0);
    check_output("t6_glitch_int_gen", {31'b0, int_gen}, 32'd0);
    intx  = 8'h01;
    first = -1;
    for (int i = 1; i <= LAT + 10; i++) begin
      tick(1);
      if (int_gen && first < 0) first = i;
      if (i == 20) intx = 8'h00;
    end
    check_output("t6_debounce_latency", 32'(first), 32'(LAT));
    read_check("t6_pend", 4'd4, 32'h1);
    apply_stimulus(4'd4, 32'hFF, 4'hF);
    tick(LAT + 5);
`endif

    $display("[TB] randomized interrupt traffic");
    random_round(8'($urandom), 8'($urandom));
    random_round(8'($urandom), 8'($urandom) | 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
